// File: rtl/read_ram_addr_gen.sv
// ============================================================================
// Module   : read_ram_addr_gen
// Brief    : Walks RAM addresses after a start pulse and streams each byte to
//            a UART transmitter over a txStart/txBusy handshake.
//            Optional trailing checksum byte: define READ_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module read_ram_addr_gen #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                RAM_LAT   = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              sclk,
    input  logic              srst_n,
    input  logic              enable,
    input  logic              start,
    input  logic [ADDR_W-1:0] dataLength,
    output logic [ADDR_W-1:0] ramAddress,
    input  logic [DATA_W-1:0] ramData,
    output logic [DATA_W-1:0] txData,
    output logic              txStart,
    input  logic              txBusy,
    output logic              finishFlag
);

    localparam int              LAT_W    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RAM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_RAM  = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_IDLE = 3'd3,
`ifdef READ_CHECKSUM_EN
        CKSUM     = 3'd5,
`endif
        DONE      = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] index_q;
    logic [ADDR_W-1:0] len_q;
    logic [LAT_W-1:0]  lat_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_start_q;
    logic              finish_q;
`ifdef READ_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic              cksum_sent_q;
`endif

    assign ramAddress = addr_q;
    assign txData     = tx_data_q;
    assign txStart    = tx_start_q;
    assign finishFlag = finish_q;

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q      <= IDLE;
            addr_q       <= BASE_ADDR;
            index_q      <= '0;
            len_q        <= '0;
            lat_q        <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            finish_q     <= 1'b0;
`ifdef READ_CHECKSUM_EN
            sum_q        <= '0;
            cksum_sent_q <= 1'b0;
`endif
        end else begin
            // txStart is a single-cycle request; only the load edges raise it
            tx_start_q <= 1'b0;
            if (!enable) begin
                state_q  <= IDLE;
                finish_q <= 1'b0;
                addr_q   <= BASE_ADDR;
                index_q  <= '0;
                lat_q    <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            len_q    <= dataLength;
                            index_q  <= '0;
                            addr_q   <= BASE_ADDR;
                            lat_q    <= '0;
                            finish_q <= 1'b0;
`ifdef READ_CHECKSUM_EN
                            sum_q        <= '0;
                            cksum_sent_q <= 1'b0;
                            if (dataLength == '0) begin
                                state_q <= CKSUM;
                            end else begin
                                state_q <= WAIT_RAM;
                            end
`else
                            if (dataLength == '0) begin
                                state_q  <= DONE;
                                finish_q <= 1'b1;
                            end else begin
                                state_q <= WAIT_RAM;
                            end
`endif
                        end
                    end

                    WAIT_RAM: begin
                        if (lat_q == LAT_LAST) begin
                            lat_q      <= '0;
                            tx_data_q  <= ramData;
                            tx_start_q <= 1'b1;
`ifdef READ_CHECKSUM_EN
                            sum_q      <= sum_q + ramData;
`endif
                            state_q    <= WAIT_BUSY;
                        end else begin
                            lat_q <= lat_q + 1'b1;
                        end
                    end

                    WAIT_BUSY: begin
                        if (txBusy) begin
                            state_q <= WAIT_IDLE;
                        end
                    end

                    WAIT_IDLE: begin
                        if (!txBusy) begin
`ifdef READ_CHECKSUM_EN
                            if (cksum_sent_q) begin
                                state_q  <= DONE;
                                finish_q <= 1'b1;
                            end else if (index_q == len_q - 1'b1) begin
                                state_q <= CKSUM;
                            end else begin
                                index_q <= index_q + 1'b1;
                                addr_q  <= addr_q + 1'b1;
                                state_q <= WAIT_RAM;
                            end
`else
                            if (index_q == len_q - 1'b1) begin
                                state_q  <= DONE;
                                finish_q <= 1'b1;
                            end else begin
                                index_q <= index_q + 1'b1;
                                addr_q  <= addr_q + 1'b1;
                                state_q <= WAIT_RAM;
                            end
`endif
                        end
                    end

`ifdef READ_CHECKSUM_EN
                    // Checksum byte reuses the data handshake; the address stays put
                    CKSUM: begin
                        tx_data_q    <= sum_q;
                        tx_start_q   <= 1'b1;
                        cksum_sent_q <= 1'b1;
                        state_q      <= WAIT_BUSY;
                    end
`endif

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
